// File: rtl/disp_mode_ctrl_pkg.sv
// disp_mode_ctrl_pkg
// Shared encodings for the front-panel display scheduler: mode/state codes,
// edit targets, special glyph nibbles and the per-field digit masks.
package disp_mode_ctrl_pkg;

  typedef logic [1:0] mode_t;
  typedef logic [1:0] tgt_t;
  typedef logic [1:0] fld_t;

  localparam mode_t MODE_TIME  = 2'd0;
  localparam mode_t MODE_DATE  = 2'd1;
  localparam mode_t MODE_ALARM = 2'd2;
  localparam mode_t MODE_EDIT  = 2'd3;

  localparam tgt_t TGT_TIME  = 2'd0;
  localparam tgt_t TGT_DATE  = 2'd1;
  localparam tgt_t TGT_ALARM = 2'd2;

  localparam fld_t FLD_LAST = 2'd2;

  localparam logic [3:0]  DASH        = 4'hF;
  localparam logic [3:0]  ALARM_GLYPH = 4'hA;
  localparam logic [31:0] DASH_WORD   = {8{DASH}};

  // Digit ranges of each editable field.
  localparam logic [31:0] MASK_HM_F0   = 32'hFF00_0000; // [31:24]
  localparam logic [31:0] MASK_HM_F1   = 32'h000F_F000; // [19:12]
  localparam logic [31:0] MASK_TIME_F2 = 32'h0000_00FF; // [7:0]
  localparam logic [31:0] MASK_ALRM_F2 = 32'h0000_000F; // [3:0]
  localparam logic [31:0] MASK_DATE_F0 = 32'h00FF_0000; // [23:16]
  localparam logic [31:0] MASK_DATE_F1 = 32'h0000_FF00; // [15:8]
  localparam logic [31:0] MASK_DATE_F2 = 32'h0000_00FF; // [7:0]

  function automatic logic [31:0] field_mask(input tgt_t tgt, input fld_t fld);
    logic [31:0] m;
    m = 32'h0;
    case (tgt)
      TGT_DATE: begin
        case (fld)
          2'd0:    m = MASK_DATE_F0;
          2'd1:    m = MASK_DATE_F1;
          2'd2:    m = MASK_DATE_F2;
          default: m = 32'h0;
        endcase
      end
      TGT_TIME, TGT_ALARM: begin
        case (fld)
          2'd0:    m = MASK_HM_F0;
          2'd1:    m = MASK_HM_F1;
          2'd2:    m = (tgt == TGT_TIME) ? MASK_TIME_F2 : MASK_ALRM_F2;
          default: m = 32'h0;
        endcase
      end
      default: m = 32'h0;
    endcase
    return m;
  endfunction

  // Show mode that corresponds to an edit target.
  function automatic mode_t show_of(input tgt_t tgt);
    mode_t m;
    case (tgt)
      TGT_DATE:  m = MODE_DATE;
      TGT_ALARM: m = MODE_ALARM;
      default:   m = MODE_TIME;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/disp_mode_ctrl_blink_tick.sv
// disp_blink_tick
// Prescaler, half-period tick, blink phase and idle timeout counter.
// Ports:
//   clk, rst       clock, async active-low reset
//   clr            restart prescaler, force blink=0, clear timeout
//   tick           one-cycle pulse when the prescaler wraps
//   blink          blink phase, toggles on every tick
//   timeout_hit    timeout counter has reached TIMEOUT_TICKS (sticky until clr)
module disp_blink_tick #(
  parameter int TICK_DIV      = 25_000_000,
  parameter int TIMEOUT_TICKS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic blink,
  output logic timeout_hit
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TOUT_MAX  = TW'(TIMEOUT_TICKS);

  logic [PW-1:0] presc_q, presc_d;
  logic          blink_q, blink_d;
  logic [TW-1:0] tout_q, tout_d;

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + 1'b1;
    blink_d = tick ? ~blink_q : blink_q;
    tout_d  = (tick && (tout_q != TOUT_MAX)) ? tout_q + 1'b1 : tout_q;
    if (clr) begin
      presc_d = '0;
      blink_d = 1'b0;
      tout_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      blink_q <= 1'b0;
      tout_q  <= '0;
    end else begin
      presc_q <= presc_d;
      blink_q <= blink_d;
      tout_q  <= tout_d;
    end
  end

  assign blink       = blink_q;
  assign timeout_hit = (tout_q == TOUT_MAX);

endmodule

// File: rtl/disp_mode_ctrl.sv
// disp_mode_ctrl
// Front-panel display scheduler: picks time/date/alarm layout for the 8-digit
// scan driver, sequences field editing from key pulses, blinks the edited
// field and issues increment requests.
// Ports:
//   clk, rst                     clock, async active-low reset
//   key_mode/key_field/key_inc   debounced one-cycle key pulses
//   time_bcd, date_bcd           {hh,mm,ss} / {yy,mm,dd} BCD
//   alarm_bcd, alarm_on          {hh,mm} BCD and alarm enable
//   disp_data                    registered nibble word, digit 7 = [31:28]
//   mode                         0 time, 1 date, 2 alarm, 3 edit
//   edit_tgt, edit_fld           field being edited (held after exit)
//   edit_inc                     one-cycle increment request
//
// state      | meaning
// MODE_TIME  | showing time, home state, no timeout
// MODE_DATE  | showing date, returns to time on timeout
// MODE_ALARM | showing alarm, returns to time on timeout
// MODE_EDIT  | editing (edit_tgt, edit_fld), field blinks
module disp_mode_ctrl
  import disp_mode_ctrl_pkg::*;
#(
  parameter int TICK_DIV      = 25_000_000,
  parameter int TIMEOUT_TICKS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode,
  input  logic        key_field,
  input  logic        key_inc,
  input  logic [23:0] time_bcd,
  input  logic [23:0] date_bcd,
  input  logic [15:0] alarm_bcd,
  input  logic        alarm_on,
  output logic [31:0] disp_data,
  output logic [1:0]  mode,
  output logic [1:0]  edit_tgt,
  output logic [1:0]  edit_fld,
  output logic        edit_inc
);

  mode_t       state_q, state_d;
  tgt_t        edit_tgt_q, edit_tgt_d;
  fld_t        edit_fld_q, edit_fld_d;
  logic        edit_inc_q, edit_inc_d;
  logic [31:0] disp_data_q, disp_data_d;

  logic any_key;
  logic tick_unused;
  logic blink;
  logic timeout_hit;

  assign any_key = key_mode | key_field | key_inc;

  disp_blink_tick #(
    .TICK_DIV      (TICK_DIV),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) u_blink_tick (
    .clk         (clk),
    .rst         (rst),
    .clr         (any_key),
    .tick        (tick_unused),
    .blink       (blink),
    .timeout_hit (timeout_hit)
  );

  // A key in the same cycle as the timeout wins: it restarts the timer.
  always_comb begin
    state_d    = state_q;
    edit_tgt_d = edit_tgt_q;
    edit_fld_d = edit_fld_q;
    edit_inc_d = 1'b0;
    case (state_q)
      MODE_TIME: begin
        if (key_mode) begin
          state_d = MODE_DATE;
        end else if (key_field) begin
          state_d    = MODE_EDIT;
          edit_tgt_d = TGT_TIME;
          edit_fld_d = 2'd0;
        end
      end
      MODE_DATE: begin
        if (key_mode) begin
          state_d = MODE_ALARM;
        end else if (key_field) begin
          state_d    = MODE_EDIT;
          edit_tgt_d = TGT_DATE;
          edit_fld_d = 2'd0;
        end else if (timeout_hit && !any_key) begin
          state_d = MODE_TIME;
        end
      end
      MODE_ALARM: begin
        if (key_mode) begin
          state_d = MODE_TIME;
        end else if (key_field) begin
          state_d    = MODE_EDIT;
          edit_tgt_d = TGT_ALARM;
          edit_fld_d = 2'd0;
        end else if (timeout_hit && !any_key) begin
          state_d = MODE_TIME;
        end
      end
      default: begin
        if (key_mode) begin
          state_d = show_of(edit_tgt_q);
        end else if (key_field) begin
          if (edit_fld_q == FLD_LAST) begin
            state_d = show_of(edit_tgt_q);
          end else begin
            edit_fld_d = edit_fld_q + 2'd1;
          end
        end else if (key_inc) begin
          edit_inc_d = 1'b1;
        end else if (timeout_hit) begin
          state_d = MODE_TIME;
        end
      end
    endcase
  end

  logic [31:0] layout;
  logic [31:0] mask;
  tgt_t        lay_tgt;

  always_comb begin
    case (state_q)
      MODE_DATE:  lay_tgt = TGT_DATE;
      MODE_ALARM: lay_tgt = TGT_ALARM;
      MODE_EDIT:  lay_tgt = edit_tgt_q;
      default:    lay_tgt = TGT_TIME;
    endcase

    case (lay_tgt)
      TGT_DATE:  layout = {4'h2, 4'h0, date_bcd};
      TGT_ALARM: layout = {alarm_bcd[15:8], DASH, alarm_bcd[7:0], DASH,
                           ALARM_GLYPH, 3'b000, alarm_on};
      default:   layout = {time_bcd[23:16], DASH, time_bcd[15:8], DASH,
                           time_bcd[7:0]};
    endcase

    mask = ((state_q == MODE_EDIT) && blink) ? field_mask(edit_tgt_q, edit_fld_q) : 32'h0;
    // Blanked digits show DASH; since DASH is all ones, OR-ing the mask is enough.
    disp_data_d = (layout & ~mask) | (DASH_WORD & mask);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= MODE_TIME;
      edit_tgt_q  <= TGT_TIME;
      edit_fld_q  <= 2'd0;
      edit_inc_q  <= 1'b0;
      disp_data_q <= DASH_WORD;
    end else begin
      state_q     <= state_d;
      edit_tgt_q  <= edit_tgt_d;
      edit_fld_q  <= edit_fld_d;
      edit_inc_q  <= edit_inc_d;
      disp_data_q <= disp_data_d;
    end
  end

  assign disp_data = disp_data_q;
  assign mode      = state_q;
  assign edit_tgt  = edit_tgt_q;
  assign edit_fld  = edit_fld_q;
  assign edit_inc  = edit_inc_q;

endmodule
